// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register chain.
// Carries a generic payload through STAGES valid/ready register stages.
// Empty stages collapse as bubbles behind a blocked output. An optional
// one-entry input skid buffer makes in_ready_o a pure register output.
// flush_i discards every held entry. stall_i freezes the whole chain.
module pipe_stage_elastic #(
    parameter int DW     = 32,
    parameter int STAGES = 1,
    parameter int SKID   = 1,
    parameter int CW     = $clog2(STAGES + 2)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [CW-1:0] occupancy_o
);

    // Per-stage state; stage STAGES-1 faces the output.
    logic [STAGES-1:0] v;
    logic [DW-1:0]     d [STAGES];

    // rdy[k]: stage k may load this cycle. rdy[STAGES] is the downstream ready.
    logic [STAGES:0]   rdy;
    logic              rdy_acc;

    // Stage-0 source after skid selection.
    logic              skid_valid;
    logic              src_valid;
    logic [DW-1:0]     src_data;

    // A stage may load only when the chain is neither frozen nor being flushed.
    logic              advance;
    assign advance = !stall_i && !flush_i;

    // Backward ready chain: a stage is ready if it is empty or the stage after it moves.
    always_comb begin
        // NOTE: rdy_acc is a combinational scratch variable, so blocking '=' is
        // correct here; registers elsewhere use '<=' to avoid ordering races.
        rdy_acc     = out_ready_i;
        rdy         = '0;
        rdy[STAGES] = rdy_acc;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_acc = !v[k] || rdy_acc;
            rdy[k]  = rdy_acc;
        end
    end

    if (SKID != 0) begin : g_skid
        logic          skid_q;
        logic [DW-1:0] skid_d;

        // Skid register: catches an accepted input that stage 0 cannot take,
        // and drains into stage 0 as soon as it can move.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                skid_q <= 1'b0;
                skid_d <= '0;
            end else if (flush_i) begin
                skid_q <= 1'b0;
            end else if (skid_q) begin
                if (rdy[0] && !stall_i) begin
                    skid_q <= 1'b0;
                end
            end else if (in_valid_i && !(rdy[0] && !stall_i)) begin
                skid_q <= 1'b1;
                skid_d <= in_data_i;
            end
        end

        // Skid entry has priority; while it is full no new input is accepted.
        assign skid_valid = skid_q;
        assign in_ready_o = !skid_q;
        assign src_valid  = skid_q || in_valid_i;
        assign src_data   = skid_q ? skid_d : in_data_i;
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign in_ready_o = rdy[0] && !stall_i && !flush_i;
        assign src_valid  = in_valid_i;
        assign src_data   = in_data_i;
    end

    // Stage registers: each stage takes its predecessor whenever it is ready;
    // data only moves with a valid entry, so bubbles never overwrite payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v <= '0;
            // NOTE: the payload registers are a handful of flops, not a RAM,
            // so they are cleared too and out_data_o reads 0 after reset.
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else if (flush_i) begin
            v <= '0;
        end else if (advance) begin
            if (rdy[0]) begin
                v[0] <= src_valid;
                if (src_valid) begin
                    d[0] <= src_data;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    assign out_valid_o = v[STAGES-1];
    assign out_data_o  = d[STAGES-1];

    // Occupancy: number of valid stages plus a held skid entry.
    always_comb begin
        occupancy_o = CW'(skid_valid);
        for (int k = 0; k < STAGES; k++) begin
            occupancy_o = occupancy_o + CW'(v[k]);
        end
    end

    // A presented but unaccepted output must not change under the consumer.
    a_out_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o)
    );

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parameterised elastic pipeline register chain. Successor to the fixed-field stage registers between processor stages.
- Carries one generic payload bus through STAGES register stages, with a valid/ready handshake on each side.
- Empty stages collapse as bubbles, an optional input skid buffer makes in_ready_o registered, and flush and legacy global stall controls are provided.
- Used between decode/execute/memory stages and in front of peripherals such as data memory and UART.

Parameters:
- DW, 32, payload width in bits. Legal range 1..256.
- STAGES, 1, number of register stages. Legal range 1..8.
- SKID, 1, 1 = one-entry input skid buffer with registered in_ready_o; 0 = no skid buffer, combinational in_ready_o.
- CW, $clog2(STAGES+2), width of occupancy_o (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all held entries.
- stall_i  input  1  global hold; freezes every stage.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  block can accept a payload this cycle.
- in_data_i  input  DW  upstream payload.
- out_valid_o  output  1  last stage holds a valid payload.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DW  payload of the last stage.
- occupancy_o  output  CW  number of valid entries held (stages plus skid).

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All stage valid bits, skid valid and stage/skid data clear to 0.
  - Outputs during reset: out_valid_o=0, out_data_o=0, occupancy_o=0.
  - in_ready_o=1 when SKID=1; when SKID=0 it equals !stall_i.
  - Deassertion mid-stream loses all entries; no partial state survives.
- State per stage k (k=0..STAGES-1): v[k], d[k]. Stage STAGES-1 drives the outputs.
- Advance rule, no stall, no flush:
  - rdy[STAGES] = out_ready_i.
  - rdy[k] = !v[k] | rdy[k+1]. This chain is combinational.
  - Stage k loads v[k-1]/d[k-1] when rdy[k]=1. Stage 0 loads its source: skid entry if skid valid, else in_data_i/in_valid_i.
  - d[k] updates only when the incoming valid is 1. v[k] always updates when rdy[k]=1.
- Transfer occurs when valid&ready on the same edge, on either port.
- Latency with the skid empty and no backpressure: input accepted at edge n appears on out_* after edge n+STAGES-1, i.e. visible in cycle n+STAGES.
- Throughput: one payload per cycle sustained. Bubbles are squeezed out behind a blocked output.
- Skid (SKID=1):
  - in_ready_o = !skid_valid, a pure register output.
  - Accepted input goes directly to stage 0 if rdy[0]&!stall_i. Otherwise it is captured in the skid.
  - Skid drains into stage 0 when rdy[0]&!stall_i. The skid has priority over in_data_i.
  - When the skid drains in the same cycle as a new input arrives: in_ready_o was 0, so no input is accepted that cycle.
- SKID=0: in_ready_o = rdy[0] & !stall_i & !flush_i.
- stall_i=1:
  - No stage register changes and out_valid_o holds.
  - A downstream handshake is not consumed: the block treats out_ready_i as 0.
  - With SKID=1 one input may still be accepted into an empty skid.
- flush_i=1 (priority over stall_i and every handshake):
  - All v[k] and skid valid clear at the edge. Data registers are untouched.
  - An input presented in the flush cycle is dropped even if in_ready_o=1.
  - out_valid_o is still valid during the flush cycle, but a downstream transfer in that cycle is not counted.
- occupancy_o: combinational popcount of v[] plus skid valid. Range 0..STAGES+SKID.
- Boundaries:
  - Full (all v=1, skid full, out_ready_i=0): in_ready_o=0 and all entries hold.
  - Full with out_ready_i=1: the whole chain shifts one step in a single cycle.
  - Assertions: out_data_o stable while out_valid_o&!out_ready_i, and no flush.

Test Plan:
- STAGES=3, SKID=1: stream 0x1..0x10 with out_ready_i=1 -> out_data_o shows 0x1 in cycle 3 after the first accept, then one word per cycle, in order, no gaps.
- STAGES=3: send 0xA, 0xB with an idle cycle between, out_ready_i=0 for 6 cycles -> entries collapse; occupancy_o=2; on release 0xA then 0xB on consecutive cycles.
- STAGES=2, SKID=1, out_ready_i=0, in_valid_i held with 0x1..0x5 -> accepts 0x1, 0x2, 0x3 (skid); in_ready_o=0 next cycle; occupancy_o=3; no data loss after release.
- Chain holding 3 entries, flush_i pulse concurrent with in_valid_i=1 (0x77) -> next cycle occupancy_o=0, out_valid_o=0, and 0x77 never emerges.
- stall_i=1 for 4 cycles with out_ready_i=1 and full chain -> out_data_o constant, no transfers; SKID=1 accepts exactly one input; resume yields the original order.
- rst_ni pulled low asynchronously mid-stream (between edges) -> out_valid_o=0 and occupancy_o=0 immediately; after release the first new input emerges with nominal latency.
